// File: rtl/icmp_header_parser.sv
// icmp_header_parser
// Parses the 8-byte ICMP header from a big-endian beat stream and checks
// the ones'-complement checksum over the whole message.
//
// Parameters
//   AVL_SIZE  beat width in bits (8, 16 or 32)
//   LEN_SIZE  width of the byte counter and pkt_len
//
// Ports
//   clk, sync_reset_n                  clock, synchronous active-low reset
//   data_in_valid, data_in, sop, eop   input beat stream
//   icmp_type, code, checksum,
//   identifier, seq_num                captured header fields
//   is_echo_req, is_echo_rep           echo request / reply decode
//   header_valid                       pulse once all header bytes are captured
//   pkt_done                           pulse after the eop beat
//   checksum_ok, short_err, pkt_len    end-of-message status
//
// state   | meaning
// IDLE    | waiting for a sop beat; all other beats are dropped
// HDR     | collecting header bytes 0..7
// PAYLOAD | header complete, summing payload until eop
module icmp_header_parser #(
  parameter int AVL_SIZE = 8,
  parameter int LEN_SIZE = 16
) (
  input  logic                clk,
  input  logic                sync_reset_n,
  input  logic                data_in_valid,
  input  logic [AVL_SIZE-1:0] data_in,
  input  logic                sop,
  input  logic                eop,
  output logic [7:0]          icmp_type,
  output logic [7:0]          code,
  output logic [15:0]         checksum,
  output logic [15:0]         identifier,
  output logic [15:0]         seq_num,
  output logic                is_echo_req,
  output logic                is_echo_rep,
  output logic                header_valid,
  output logic                pkt_done,
  output logic                checksum_ok,
  output logic                short_err,
  output logic [LEN_SIZE-1:0] pkt_len
);

  localparam int BYTES = AVL_SIZE / 8;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic                accept;
  logic                hdr_done;
  logic [LEN_SIZE-1:0] cnt_q, cnt_base, cnt_d;
  logic [LEN_SIZE:0]   cnt_sum;
  logic [31:0]         acc_q, acc_base, acc_d, final_sum;
  logic [31:0]         beat_add, pad_add;
  logic [16:0]         fold1;
  logic [15:0]         folded;
  logic [7:0]          hdr_q [8];
  logic [7:0]          hdr_d [8];

  // Beats only count once a message is open or when they open one.
  assign accept = data_in_valid && (sop || state_q != IDLE);

  // A sop beat starts from zero rather than from the leftovers of an
  // abandoned message.
  assign cnt_base = sop ? '0 : cnt_q;
  assign cnt_sum  = {1'b0, cnt_base} + (LEN_SIZE+1)'(BYTES);
  assign cnt_d    = cnt_sum[LEN_SIZE] ? '1 : cnt_sum[LEN_SIZE-1:0];
  assign hdr_done = (cnt_base < LEN_SIZE'(8)) && (cnt_d >= LEN_SIZE'(8));

  generate
    if (AVL_SIZE == 8) begin : g_pair
      // Byte-wide beats are paired into 16-bit words, high byte first.
      logic       pend_q;
      logic       pend_base;
      logic [7:0] pend_byte_q;

      assign pend_base = pend_q && !sop;
      assign beat_add  = pend_base ? {16'h0, pend_byte_q, data_in} : 32'h0;
      // If this beat is left unpaired, it counts zero-padded should eop land here.
      assign pad_add   = pend_base ? 32'h0 : {16'h0, data_in, 8'h00};

      always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
          pend_q      <= 1'b0;
          pend_byte_q <= 8'h00;
        end else if (accept) begin
          pend_q      <= !pend_base;
          pend_byte_q <= data_in;
        end
      end
    end else begin : g_word
      logic [31:0] data_w;
      assign data_w   = 32'(data_in) << (32 - AVL_SIZE);
      assign beat_add = {16'h0, data_w[31:16]} + {16'h0, data_w[15:0]};
      assign pad_add  = 32'h0;
    end
  endgenerate

  assign acc_base  = sop ? 32'h0 : acc_q;
  assign acc_d     = acc_base + beat_add;
  assign final_sum = acc_d + pad_add;
  // Two end-around folds are enough: the first leaves at most one carry.
  assign fold1     = {1'b0, final_sum[15:0]} + {1'b0, final_sum[31:16]};
  assign folded    = fold1[15:0] + {15'h0, fold1[16]};

  always_comb begin
    hdr_d = hdr_q;
    for (int i = 0; i < BYTES; i++) begin
      if (int'(cnt_base) + i < 8)
        hdr_d[3'(int'(cnt_base) + i)] = data_in[AVL_SIZE-1-8*i -: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_in_valid && sop) begin
          if (eop)           state_d = IDLE;
          else if (hdr_done) state_d = PAYLOAD;
          else               state_d = HDR;
        end
      end
      HDR, PAYLOAD: begin
        if (data_in_valid) begin
          if (eop)           state_d = IDLE;
          else if (hdr_done) state_d = PAYLOAD;
          else if (sop)      state_d = HDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      cnt_q <= '0;
      acc_q <= 32'h0;
      for (int i = 0; i < 8; i++) hdr_q[i] <= 8'h00;
    end else if (accept) begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      hdr_q <= hdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      icmp_type    <= 8'h00;
      code         <= 8'h00;
      checksum     <= 16'h0;
      identifier   <= 16'h0;
      seq_num      <= 16'h0;
      is_echo_req  <= 1'b0;
      is_echo_rep  <= 1'b0;
      header_valid <= 1'b0;
      pkt_done     <= 1'b0;
      checksum_ok  <= 1'b0;
      short_err    <= 1'b0;
      pkt_len      <= '0;
    end else begin
      header_valid <= 1'b0;
      pkt_done     <= 1'b0;
      if (accept && sop) begin
        checksum_ok <= 1'b0;
        short_err   <= 1'b0;
      end
      if (accept && hdr_done) begin
        header_valid <= 1'b1;
        icmp_type    <= hdr_d[0];
        code         <= hdr_d[1];
        checksum     <= {hdr_d[2], hdr_d[3]};
        identifier   <= {hdr_d[4], hdr_d[5]};
        seq_num      <= {hdr_d[6], hdr_d[7]};
        is_echo_req  <= (hdr_d[0] == 8'd8) && (hdr_d[1] == 8'd0);
        is_echo_rep  <= (hdr_d[0] == 8'd0) && (hdr_d[1] == 8'd0);
      end
      if (accept && eop) begin
        pkt_done    <= 1'b1;
        pkt_len     <= cnt_d;
        short_err   <= cnt_d < LEN_SIZE'(8);
        checksum_ok <= (cnt_d >= LEN_SIZE'(8)) && (folded == 16'hFFFF);
      end
    end
  end

endmodule

// File: doc/icmp_header_parser.md
ICMP_HEADER_PARSER -- requirements
Module: icmp_header_parser

Interface
REQ-001 Parameter AVL_SIZE, default 8: input beat width in bits; legal values 8, 16, 32.
REQ-002 Parameter LEN_SIZE, default 16: width of the byte counter and of pkt_len.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 sync_reset_n  input  1  reset, synchronous and active-low.
REQ-005 data_in_valid  input  1  qualifies data_in, sop and eop; beats with it low are ignored.
REQ-006 data_in  input  AVL_SIZE  ICMP message beat, big-endian; the first byte is in the MSBs.
REQ-007 sop  input  1  first beat of an ICMP message.
REQ-008 eop  input  1  last beat of an ICMP message.
REQ-009 icmp_type, code  output  8 each  header bytes 0 and 1.
REQ-010 checksum, identifier, seq_num  output  16 each  header bytes 2-3, 4-5 and 6-7.
REQ-011 is_echo_req, is_echo_rep  output  1 each  high when type=8/code=0 or type=0/code=0 respectively.
REQ-012 header_valid  output  1  one-cycle pulse when all eight header bytes are captured.
REQ-013 pkt_done  output  1  one-cycle pulse at message end.
REQ-014 checksum_ok, short_err  output  1 each  end-of-message status, valid while pkt_done is high and held until the next sop.
REQ-015 pkt_len  output  LEN_SIZE  byte count of the finished message.

Function
REQ-016 The FSM SHALL have three states: IDLE, HDR and PAYLOAD.
REQ-017 IDLE SHALL ignore beats until a valid beat with sop=1 arrives.
REQ-018 A valid sop beat SHALL clear the byte counter and the checksum accumulator, then count its own bytes.
REQ-019 A valid sop beat SHALL move the FSM to HDR, or to PAYLOAD if the beat already completes byte 7.
REQ-020 HDR SHALL move to PAYLOAD on the valid beat that holds byte 7.
REQ-021 A valid eop beat SHALL return the FSM to IDLE from any state.
REQ-022 Header fields SHALL be captured byte by byte by byte index, for any AVL_SIZE.
REQ-023 header_valid SHALL assert one cycle after the beat holding byte 7 is accepted.
REQ-024 Header field outputs SHALL hold their values until the next header completes.
REQ-025 Per valid beat, the byte counter SHALL add AVL_SIZE/8; it saturates at all-ones.
REQ-026 The checksum SHALL be a 16-bit ones'-complement sum of the whole message with end-around carry, accumulated in a 32-bit register and folded at eop.
REQ-027 When AVL_SIZE=8, bytes SHALL be paired high then low; an odd final byte is padded with a zero low byte.
REQ-028 When AVL_SIZE is 16 or 32, the message length SHALL be a whole number of beats; there is no byte-enable.
REQ-029 pkt_done SHALL assert one cycle after a valid eop beat.
REQ-030 At pkt_done: pkt_len = final byte count; checksum_ok = 1 when the folded sum is 16'hFFFF.
REQ-031 At pkt_done: short_err = 1 when fewer than 8 bytes were received; checksum_ok is then forced to 0 and header_valid does not fire.
REQ-032 sop and eop on the same beat SHALL be treated as a one-beat message.
REQ-033 A sop in HDR or PAYLOAD SHALL abandon the current message with no pkt_done and restart it.
REQ-034 A valid beat without sop in IDLE SHALL be dropped.
REQ-035 data_in_valid low SHALL freeze the FSM, counters and accumulator.

Reset
REQ-036 When sync_reset_n=0 at a clock edge, the FSM SHALL go to IDLE and all counters, the accumulator and all outputs SHALL become 0, including mid-message.
REQ-037 After reset, a new message SHALL need a fresh sop.

Verification
REQ-038 AVL_SIZE=8, bytes 08 00 F7 FD 00 01 00 01 with eop on the last -> header_valid, then is_echo_req=1, checksum=F7FD, identifier=0001, seq_num=0001; pkt_done with pkt_len=8, checksum_ok=1.
REQ-039 Same message with byte 3 = FE -> checksum_ok=0, short_err=0.
REQ-040 AVL_SIZE=32, 2 header beats plus 3 payload beats, valid gapped every other cycle -> pkt_len=20; checksum_ok=1 if and only if the checksum is correct.
REQ-041 AVL_SIZE=8, 5-byte message -> no header_valid; pkt_done with short_err=1, pkt_len=5.
REQ-042 sop re-asserted mid-payload, then a good 9-byte odd-length message -> exactly one pkt_done, pkt_len=9, checksum_ok=1 using zero padding.
REQ-043 sync_reset_n=0 during HDR -> outputs 0 next cycle; following beats without sop are ignored.
